// File: rtl/oled_spi_cmd_receiver.sv
// Receive-side model of the OLED SPI/power pins: deserializes bytes and decodes
// the SSD1306 init command subset into shadow registers with sticky protocol errors.
module oled_spi_cmd_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SPI_CS,
  input  logic       SPI_SCLK,
  input  logic       SPI_SDO,
  input  logic       SPI_DC,
  input  logic       OLED_RES,
  input  logic       OLED_VDD,
  input  logic       OLED_VBAT,
  output logic       RX_VALID,
  output logic [7:0] RX_BYTE,
  output logic       RX_IS_DATA,
  output logic       DISP_ON,
  output logic       CHARGE_PUMP_EN,
  output logic [7:0] CONTRAST,
  output logic [7:0] PRECHARGE,
  output logic       SEG_REMAP,
  output logic       COM_SCAN_REV,
  output logic [7:0] COM_CFG,
  output logic       ENTIRE_ON,
  output logic       DISP_ACTIVE,
  output logic [7:0] CMD_COUNT,
  output logic       FRAME_ERR,
  output logic       CMD_ERR,
  output logic       UNKNOWN_CMD
);

  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_SEG_NORM   = 8'hA0;
  localparam logic [7:0] OP_SEG_REMAP  = 8'hA1;
  localparam logic [7:0] OP_COM_NORM   = 8'hC0;
  localparam logic [7:0] OP_COM_REV    = 8'hC8;
  localparam logic [7:0] OP_ENT_RAM    = 8'hA4;
  localparam logic [7:0] OP_ENT_ON     = 8'hA5;
  localparam logic [7:0] OP_CHG_PUMP   = 8'h8D;
  localparam logic [7:0] OP_PRECHARGE  = 8'hD9;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_COM_CFG    = 8'hDA;

  localparam logic [7:0] DEF_CONTRAST  = 8'h7F;
  localparam logic [7:0] DEF_PRECHARGE = 8'h22;
  localparam logic [7:0] DEF_COM_CFG   = 8'h12;

  // Pin vector order {vbat, vdd, res, dc, sdo, sclk, cs}; idle values reload on reset
  // so no spurious edges or rail-on indications appear as RST releases.
  localparam int         NPIN      = 7;
  localparam logic [6:0] SYNC_IDLE = 7'b1110011;

  typedef enum logic {ST_CMD, ST_ARG} state_t;

  logic [NPIN-1:0] pin_raw;
  logic [NPIN-1:0] sync_q [SYNC_STAGES];
  logic [NPIN-1:0] pin_s;

  logic cs_s, sclk_s, sdo_s, dc_s, res_s, vdd_s, vbat_s;
  logic cs_prev, sclk_prev;
  logic sclk_rise, cs_rise, cap_en, bit_stb, byte_done, res_low;

  logic [7:0] shift_q;
  logic [2:0] bit_cnt;
  logic [7:0] full_byte;

  logic       rx_valid_q;
  logic [7:0] rx_byte_q;
  logic       rx_is_data_q;
  logic       frame_err_q;

  state_t     state_q, state_d;
  logic [7:0] pending_q, pending_d;
  logic       disp_on_q, disp_on_d;
  logic       cp_en_q, cp_en_d;
  logic [7:0] contrast_q, contrast_d;
  logic [7:0] precharge_q, precharge_d;
  logic       seg_remap_q, seg_remap_d;
  logic       com_rev_q, com_rev_d;
  logic [7:0] com_cfg_q, com_cfg_d;
  logic       entire_on_q, entire_on_d;
  logic [7:0] cmd_count_q, cmd_count_d;
  logic       cmd_err_q, cmd_err_d;
  logic       unknown_q, unknown_d;

  assign pin_raw = {OLED_VBAT, OLED_VDD, OLED_RES, SPI_DC, SPI_SDO, SPI_SCLK, SPI_CS};

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= pin_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign pin_s  = sync_q[SYNC_STAGES-1];
  assign cs_s   = pin_s[0];
  assign sclk_s = pin_s[1];
  assign sdo_s  = pin_s[2];
  assign dc_s   = pin_s[3];
  assign res_s  = pin_s[4];
  assign vdd_s  = pin_s[5];
  assign vbat_s = pin_s[6];

  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_prev   <= 1'b1;
      sclk_prev <= 1'b1;
    end else begin
      cs_prev   <= cs_s;
      sclk_prev <= sclk_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_prev;
  assign cs_rise   = cs_s & ~cs_prev;
  // CS counts as still asserted on the cycle it rises, so a final bit that
  // lands together with the CS release still completes its byte.
  assign cap_en    = ~cs_s | ~cs_prev;
  assign bit_stb   = sclk_rise & cap_en;
  assign byte_done = bit_stb & (bit_cnt == 3'd7);
  assign full_byte = {shift_q[6:0], sdo_s};
  assign res_low   = ~res_s;

  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q      <= 8'h00;
      bit_cnt      <= 3'd0;
      rx_valid_q   <= 1'b0;
      rx_byte_q    <= 8'h00;
      rx_is_data_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (res_low) begin
        shift_q <= 8'h00;
        bit_cnt <= 3'd0;
      end else if (bit_stb) begin
        shift_q <= full_byte;
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_valid_q   <= 1'b1;
          rx_byte_q    <= full_byte;
          rx_is_data_q <= dc_s;
        end else if (cs_rise) begin
          bit_cnt     <= 3'd0;
          frame_err_q <= 1'b1;
        end
      end else if (cs_s) begin
        bit_cnt <= 3'd0;
        if (cs_rise && bit_cnt != 3'd0) frame_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_CMD;
      pending_q   <= 8'h00;
      disp_on_q   <= 1'b0;
      cp_en_q     <= 1'b0;
      contrast_q  <= DEF_CONTRAST;
      precharge_q <= DEF_PRECHARGE;
      seg_remap_q <= 1'b0;
      com_rev_q   <= 1'b0;
      com_cfg_q   <= DEF_COM_CFG;
      entire_on_q <= 1'b0;
      cmd_count_q <= 8'h00;
      cmd_err_q   <= 1'b0;
      unknown_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      disp_on_q   <= disp_on_d;
      cp_en_q     <= cp_en_d;
      contrast_q  <= contrast_d;
      precharge_q <= precharge_d;
      seg_remap_q <= seg_remap_d;
      com_rev_q   <= com_rev_d;
      com_cfg_q   <= com_cfg_d;
      entire_on_q <= entire_on_d;
      cmd_count_q <= cmd_count_d;
      cmd_err_q   <= cmd_err_d;
      unknown_q   <= unknown_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    disp_on_d   = disp_on_q;
    cp_en_d     = cp_en_q;
    contrast_d  = contrast_q;
    precharge_d = precharge_q;
    seg_remap_d = seg_remap_q;
    com_rev_d   = com_rev_q;
    com_cfg_d   = com_cfg_q;
    entire_on_d = entire_on_q;
    cmd_count_d = cmd_count_q;
    cmd_err_d   = cmd_err_q;
    unknown_d   = unknown_q;

    // Display reset wins over a byte finishing on the same cycle; counters and
    // sticky flags describe the link, not the panel, so they survive it.
    if (res_low) begin
      state_d     = ST_CMD;
      pending_d   = 8'h00;
      disp_on_d   = 1'b0;
      cp_en_d     = 1'b0;
      contrast_d  = DEF_CONTRAST;
      precharge_d = DEF_PRECHARGE;
      seg_remap_d = 1'b0;
      com_rev_d   = 1'b0;
      com_cfg_d   = DEF_COM_CFG;
      entire_on_d = 1'b0;
    end else if (byte_done) begin
      case (state_q)
        ST_CMD: begin
          if (!dc_s) begin
            cmd_count_d = cmd_count_q + 8'd1;
            case (full_byte)
              OP_DISP_OFF:  disp_on_d   = 1'b0;
              OP_DISP_ON:   disp_on_d   = 1'b1;
              OP_SEG_NORM:  seg_remap_d = 1'b0;
              OP_SEG_REMAP: seg_remap_d = 1'b1;
              OP_COM_NORM:  com_rev_d   = 1'b0;
              OP_COM_REV:   com_rev_d   = 1'b1;
              OP_ENT_RAM:   entire_on_d = 1'b0;
              OP_ENT_ON:    entire_on_d = 1'b1;
              OP_CHG_PUMP, OP_PRECHARGE, OP_CONTRAST, OP_COM_CFG: begin
                // Two-byte command: counted once its argument lands.
                cmd_count_d = cmd_count_q;
                pending_d   = full_byte;
                state_d     = ST_ARG;
              end
              default:      unknown_d   = 1'b1;
            endcase
          end
        end
        ST_ARG: begin
          state_d   = ST_CMD;
          pending_d = 8'h00;
          if (dc_s) begin
            cmd_err_d = 1'b1;
          end else begin
            cmd_count_d = cmd_count_q + 8'd1;
            case (pending_q)
              OP_CHG_PUMP:  cp_en_d     = full_byte[2];
              OP_PRECHARGE: precharge_d = full_byte;
              OP_CONTRAST:  contrast_d  = full_byte;
              OP_COM_CFG:   com_cfg_d   = full_byte;
              default:      ;
            endcase
          end
        end
        default: state_d = ST_CMD;
      endcase
    end
  end

  assign RX_VALID       = rx_valid_q;
  assign RX_BYTE        = rx_byte_q;
  assign RX_IS_DATA     = rx_is_data_q;
  assign DISP_ON        = disp_on_q;
  assign CHARGE_PUMP_EN = cp_en_q;
  assign CONTRAST       = contrast_q;
  assign PRECHARGE      = precharge_q;
  assign SEG_REMAP      = seg_remap_q;
  assign COM_SCAN_REV   = com_rev_q;
  assign COM_CFG        = com_cfg_q;
  assign ENTIRE_ON      = entire_on_q;
  assign DISP_ACTIVE    = disp_on_q & cp_en_q & ~vdd_s & ~vbat_s;
  assign CMD_COUNT      = cmd_count_q;
  assign FRAME_ERR      = frame_err_q;
  assign CMD_ERR        = cmd_err_q;
  assign UNKNOWN_CMD    = unknown_q;

endmodule

// File: tb/tb_oled_spi_cmd_receiver.sv
// Directed bench for oled_spi_cmd_receiver: init-sequence vector table plus
// hand sequences for framing, argument errors, display reset, RST and latency.
module tb_oled_spi_cmd_receiver;

  localparam int HALF = 4;

  logic       CLK, RST;
  logic       SPI_CS, SPI_SCLK, SPI_SDO, SPI_DC;
  logic       OLED_RES, OLED_VDD, OLED_VBAT;
  logic       RX_VALID, RX_IS_DATA;
  logic [7:0] RX_BYTE, CONTRAST, PRECHARGE, COM_CFG, CMD_COUNT;
  logic       DISP_ON, CHARGE_PUMP_EN, SEG_REMAP, COM_SCAN_REV, ENTIRE_ON;
  logic       DISP_ACTIVE, FRAME_ERR, CMD_ERR, UNKNOWN_CMD;

  oled_spi_cmd_receiver #(.SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST),
    .SPI_CS(SPI_CS), .SPI_SCLK(SPI_SCLK), .SPI_SDO(SPI_SDO), .SPI_DC(SPI_DC),
    .OLED_RES(OLED_RES), .OLED_VDD(OLED_VDD), .OLED_VBAT(OLED_VBAT),
    .RX_VALID(RX_VALID), .RX_BYTE(RX_BYTE), .RX_IS_DATA(RX_IS_DATA),
    .DISP_ON(DISP_ON), .CHARGE_PUMP_EN(CHARGE_PUMP_EN), .CONTRAST(CONTRAST),
    .PRECHARGE(PRECHARGE), .SEG_REMAP(SEG_REMAP), .COM_SCAN_REV(COM_SCAN_REV),
    .COM_CFG(COM_CFG), .ENTIRE_ON(ENTIRE_ON), .DISP_ACTIVE(DISP_ACTIVE),
    .CMD_COUNT(CMD_COUNT), .FRAME_ERR(FRAME_ERR), .CMD_ERR(CMD_ERR),
    .UNKNOWN_CMD(UNKNOWN_CMD)
  );

  typedef struct packed {
    logic [7:0] rx_byte;
    logic       rx_is_data;
    logic [7:0] cmd_count;
    logic [7:0] contrast;
    logic [7:0] precharge;
    logic [7:0] com_cfg;
    logic       disp_on;
    logic       cp_en;
    logic       seg_remap;
    logic       com_rev;
    logic       entire_on;
    logic       disp_active;
    logic       cmd_err;
    logic       unknown;
    logic       frame_err;
  } st_t;

  // flags = {disp_on, cp_en, seg_remap, com_rev, entire_on}
  typedef struct {
    logic [7:0] b;
    logic       dc;
    logic [7:0] cnt;
    logic [7:0] contrast;
    logic [7:0] pre;
    logic [7:0] cfg;
    logic [4:0] flags;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;
  int rx_pulses = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (RX_VALID) rx_pulses++;

  function automatic st_t dflt();
    st_t s;
    s = '0;
    s.contrast  = 8'h7F;
    s.precharge = 8'h22;
    s.com_cfg   = 8'h12;
    return s;
  endfunction

  function automatic st_t cur();
    st_t s;
    s.rx_byte = RX_BYTE;       s.rx_is_data = RX_IS_DATA;  s.cmd_count = CMD_COUNT;
    s.contrast = CONTRAST;     s.precharge = PRECHARGE;    s.com_cfg = COM_CFG;
    s.disp_on = DISP_ON;       s.cp_en = CHARGE_PUMP_EN;   s.seg_remap = SEG_REMAP;
    s.com_rev = COM_SCAN_REV;  s.entire_on = ENTIRE_ON;    s.disp_active = DISP_ACTIVE;
    s.cmd_err = CMD_ERR;       s.unknown = UNKNOWN_CMD;    s.frame_err = FRAME_ERR;
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic shift_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      SPI_SCLK = 1'b0;
      SPI_SDO  = b[7-i];
      repeat (HALF) @(negedge CLK);
      SPI_SCLK = 1'b1;
      repeat (HALF - 1) @(negedge CLK);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    @(negedge CLK);
    SPI_DC = dc;
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    shift_bits(b, 8);
    repeat (2) @(negedge CLK);
    SPI_CS = 1'b1;
    repeat (6) @(negedge CLK);
  endtask

  vec_t tbl [12];
  st_t  e;
  int   p0, lat;

  initial begin
    RST = 1'b1; SPI_CS = 1'b1; SPI_SCLK = 1'b1; SPI_SDO = 1'b0; SPI_DC = 1'b0;
    OLED_RES = 1'b1; OLED_VDD = 1'b0; OLED_VBAT = 1'b0;

    tbl[0]  = '{8'hAE, 1'b0, 8'd1, 8'h7F, 8'h22, 8'h12, 5'b00000};
    tbl[1]  = '{8'h8D, 1'b0, 8'd1, 8'h7F, 8'h22, 8'h12, 5'b00000};
    tbl[2]  = '{8'h14, 1'b0, 8'd2, 8'h7F, 8'h22, 8'h12, 5'b01000};
    tbl[3]  = '{8'hD9, 1'b0, 8'd2, 8'h7F, 8'h22, 8'h12, 5'b01000};
    tbl[4]  = '{8'hF1, 1'b0, 8'd3, 8'h7F, 8'hF1, 8'h12, 5'b01000};
    tbl[5]  = '{8'h81, 1'b0, 8'd3, 8'h7F, 8'hF1, 8'h12, 5'b01000};
    tbl[6]  = '{8'h0F, 1'b0, 8'd4, 8'h0F, 8'hF1, 8'h12, 5'b01000};
    tbl[7]  = '{8'hA1, 1'b0, 8'd5, 8'h0F, 8'hF1, 8'h12, 5'b01100};
    tbl[8]  = '{8'hC8, 1'b0, 8'd6, 8'h0F, 8'hF1, 8'h12, 5'b01110};
    tbl[9]  = '{8'hDA, 1'b0, 8'd6, 8'h0F, 8'hF1, 8'h12, 5'b01110};
    tbl[10] = '{8'h20, 1'b0, 8'd7, 8'h0F, 8'hF1, 8'h20, 5'b01110};
    tbl[11] = '{8'hAF, 1'b0, 8'd8, 8'h0F, 8'hF1, 8'h20, 5'b11110};

    repeat (3) @(negedge CLK);
    chk("reset_state", cur(), dflt());
    chk("reset_rx_valid", RX_VALID, 1'b0);
    RST = 1'b0;
    repeat (3) @(negedge CLK);

    // Init replay
    p0 = rx_pulses;
    for (int i = 0; i < 12; i++) begin
      send_byte(tbl[i].b, tbl[i].dc);
      e = dflt();
      e.rx_byte = tbl[i].b;       e.rx_is_data = tbl[i].dc;  e.cmd_count = tbl[i].cnt;
      e.contrast = tbl[i].contrast; e.precharge = tbl[i].pre; e.com_cfg = tbl[i].cfg;
      {e.disp_on, e.cp_en, e.seg_remap, e.com_rev, e.entire_on} = tbl[i].flags;
      e.disp_active = tbl[i].flags[4] & tbl[i].flags[3];
      chk($sformatf("init[%0d]", i), cur(), e);
    end
    chk("init_rx_pulses", rx_pulses - p0, 12);
    @(negedge CLK); OLED_VBAT = 1'b1; repeat (4) @(negedge CLK);
    chk("disp_active_vbat_off", DISP_ACTIVE, 1'b0);
    OLED_VBAT = 1'b0;

    // Partial byte then CS release
    do_reset();
    p0 = rx_pulses;
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    shift_bits(8'hFF, 5);
    SPI_CS = 1'b1;
    repeat (8) @(negedge CLK);
    chk("frame_partial_no_pulse", rx_pulses - p0, 0);
    send_byte(8'hA5, 1'b0);
    e = dflt(); e.rx_byte = 8'hA5; e.cmd_count = 8'd1; e.entire_on = 1'b1; e.frame_err = 1'b1;
    chk("frame_err_then_a5", cur(), e);
    chk("frame_rx_pulses", rx_pulses - p0, 1);

    // Data byte while argument pending
    do_reset();
    send_byte(8'h81, 1'b0);
    send_byte(8'h55, 1'b1);
    e = dflt(); e.rx_byte = 8'h55; e.rx_is_data = 1'b1; e.cmd_err = 1'b1;
    chk("cmd_err_data", cur(), e);
    send_byte(8'h81, 1'b0);
    send_byte(8'h33, 1'b0);
    e = dflt(); e.rx_byte = 8'h33; e.contrast = 8'h33; e.cmd_count = 8'd1; e.cmd_err = 1'b1;
    chk("contrast_after_err", cur(), e);

    // Unsupported opcode
    do_reset();
    send_byte(8'h2E, 1'b0);
    e = dflt(); e.rx_byte = 8'h2E; e.cmd_count = 8'd1; e.unknown = 1'b1;
    chk("unknown_2e", cur(), e);

    // Display reset drops pending argument
    do_reset();
    send_byte(8'hD9, 1'b0);
    @(negedge CLK); OLED_RES = 1'b0;
    repeat (6) @(negedge CLK);
    OLED_RES = 1'b1;
    repeat (4) @(negedge CLK);
    send_byte(8'h14, 1'b0);
    e = dflt(); e.rx_byte = 8'h14; e.cmd_count = 8'd1; e.unknown = 1'b1;
    chk("oled_res_drops_arg", cur(), e);

    // RST mid-byte
    do_reset();
    send_byte(8'h81, 1'b0);
    send_byte(8'h0F, 1'b0);
    chk("contrast_loaded", CONTRAST, 8'h0F);
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    shift_bits(8'hAF, 4);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("rst_mid_byte_state", cur(), dflt());
    SPI_CS = 1'b1;
    repeat (8) @(negedge CLK);
    send_byte(8'hAF, 1'b0);
    e = dflt(); e.rx_byte = 8'hAF; e.cmd_count = 8'd1; e.disp_on = 1'b1;
    chk("after_rst_af", cur(), e);

    // Latency from 8th SCLK rising edge at the pin
    do_reset();
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    shift_bits(8'hA5, 7);
    @(negedge CLK); SPI_SCLK = 1'b0; SPI_SDO = 1'b1;
    repeat (HALF) @(negedge CLK);
    SPI_SCLK = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge CLK); #1;
      if (RX_VALID) begin
        lat = k;
        break;
      end
    end
    chk("rx_valid_latency", lat, 3);
    chk("shadow_same_edge", {ENTIRE_ON, CMD_COUNT}, {1'b1, 8'd1});
    @(negedge CLK); SPI_CS = 1'b1;
    repeat (8) @(negedge CLK);

    // CS rises together with the 8th SCLK edge
    do_reset();
    SPI_CS = 1'b0;
    repeat (HALF) @(negedge CLK);
    shift_bits(8'hAF, 7);
    @(negedge CLK); SPI_SCLK = 1'b0; SPI_SDO = 1'b1;
    repeat (HALF) @(negedge CLK);
    SPI_SCLK = 1'b1;
    SPI_CS   = 1'b1;
    repeat (8) @(negedge CLK);
    e = dflt(); e.rx_byte = 8'hAF; e.cmd_count = 8'd1; e.disp_on = 1'b1;
    chk("cs_with_last_bit", cur(), e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
